// File: rtl/tlc_pkg.sv
// ============================================================================
// Module : tlc_pkg
// Brief  : Shared types and constants for the intersection phase scheduler.
//          The WALK state exists only when PED_PHASE_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tlc_pkg;

    localparam int NUM_APPR = 4;

    localparam logic [2:0] LIGHT_G = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_R = 3'b001;

`ifdef PED_PHASE_EN
    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_WALK   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;
`endif

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter4.sv
// ============================================================================
// Module : rr_arbiter4
// Brief  : Picks the first requester after ptr in rotation order (ptr+1..ptr+3).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter4
    import tlc_pkg::*;
(
    input  logic [NUM_APPR-1:0] req,
    input  logic [1:0]          ptr,
    output logic [1:0]          gnt_idx,
    output logic                any
);

    // Scan farthest-first so the nearest requester after ptr is the final winner.
    always_comb begin
        gnt_idx = 2'd0;
        any     = 1'b0;
        for (int i = NUM_APPR - 1; i >= 1; i--) begin
            if (req[ptr + 2'(i)]) begin
                gnt_idx = ptr + 2'(i);
                any     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
// ============================================================================
// Module : intersection_phase_scheduler
// Brief  : Four-approach traffic phase FSM (GREEN/YELLOW/ALLRED) with an
//          optional pedestrian WALK phase enabled by macro PED_PHASE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module intersection_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 12,
    parameter int YELLOW_CYC = 2,
    parameter int ALLRED_CYC = 1,
    parameter int WALK_CYC   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  car_req,
`ifdef PED_PHASE_EN
    input  logic        ped_req,
    output logic        walk,
`endif
    output logic [11:0] lights,
    output logic [1:0]  cur_appr
);

    localparam int MAX_DUR = max4(GREEN_MAX, YELLOW_CYC, ALLRED_CYC, WALK_CYC);
    localparam int TW      = $clog2(MAX_DUR) + 1;

    localparam logic [TW-1:0] GMIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] Y_LAST    = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(ALLRED_CYC - 1);
`ifdef PED_PHASE_EN
    localparam logic [TW-1:0] W_LAST    = TW'(WALK_CYC - 1);
`endif

    state_t        state, state_nx;
    logic [TW-1:0] timer;
    logic [1:0]    next_appr, next_appr_nx, cur_appr_nx;
    logic          ped_pending;
    logic [3:0]    other_req;
    logic          other_pending;
    logic          green_exit;
    logic [1:0]    rr_idx;
    logic          rr_any;
    logic [2:0]    lamp_cur;

    rr_arbiter4 u_rr (
        .req     (car_req),
        .ptr     (cur_appr),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    assign other_req     = car_req & ~(4'b0001 << cur_appr);
    assign other_pending = (|other_req) | ped_pending;

    // Leave on demand from elsewhere, or fall back to the highway when idle.
    assign green_exit = (timer >= GMIN_LAST) &&
                        ((other_pending && (!car_req[cur_appr] || timer >= GMAX_LAST)) ||
                         (cur_appr != 2'd0 && car_req == 4'd0 && !ped_pending));

    always_comb begin
        state_nx     = state;
        cur_appr_nx  = cur_appr;
        next_appr_nx = next_appr;
        case (state)
            ST_GREEN: begin
                if (green_exit) begin
                    state_nx     = ST_YELLOW;
                    next_appr_nx = rr_any ? rr_idx : 2'd0;
                end
            end
            ST_YELLOW: begin
                if (timer == Y_LAST) state_nx = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (timer == AR_LAST) begin
                    state_nx    = ST_GREEN;
                    cur_appr_nx = next_appr;
`ifdef PED_PHASE_EN
                    if (ped_pending) begin
                        state_nx    = ST_WALK;
                        cur_appr_nx = cur_appr;
                    end
`endif
                end
            end
`ifdef PED_PHASE_EN
            ST_WALK: begin
                if (timer == W_LAST) begin
                    state_nx    = ST_GREEN;
                    cur_appr_nx = next_appr;
                end
            end
`endif
            default: state_nx = ST_GREEN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_GREEN;
            cur_appr  <= 2'd0;
            next_appr <= 2'd0;
            timer     <= '0;
        end else begin
            state     <= state_nx;
            cur_appr  <= cur_appr_nx;
            next_appr <= next_appr_nx;
            if (state_nx != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + 1'b1;
            end
        end
    end

`ifdef PED_PHASE_EN
    // A press coinciding with WALK entry is served by that same walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pending <= 1'b0;
        end else if (state_nx == ST_WALK && state != ST_WALK) begin
            ped_pending <= 1'b0;
        end else if (ped_req) begin
            ped_pending <= 1'b1;
        end
    end

    assign walk = (state == ST_WALK);
`else
    assign ped_pending = 1'b0;
`endif

    always_comb begin
        lamp_cur = LIGHT_R;
        if (state == ST_GREEN) begin
            lamp_cur = LIGHT_G;
        end else if (state == ST_YELLOW) begin
            lamp_cur = LIGHT_Y;
        end
    end

    for (genvar i = 0; i < NUM_APPR; i++) begin : g_lamp
        assign lights[3*i +: 3] = (cur_appr == 2'(i)) ? lamp_cur : LIGHT_R;
    end

endmodule

`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
// ============================================================================
// Module : tb_intersection_phase_scheduler
// Brief  : Scoreboard bench for intersection_phase_scheduler (directed vectors).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_intersection_phase_scheduler;
    import tlc_pkg::*;

    typedef struct {
        logic [11:0] lights;
        logic [1:0]  appr;
        logic        walk;
        string       tag;
    } exp_t;

    localparam logic [11:0] RST_L = 12'b001_001_001_100;
    localparam logic [11:0] ALL_R = 12'b001_001_001_001;

    exp_t exp_q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic [3:0]  car_req = 4'd0;
    logic [11:0] lights;
    logic [1:0]  cur_appr;
    logic        walk;
`ifdef PED_PHASE_EN
    logic        ped_req = 1'b0;
`else
    assign walk = 1'b0;
`endif

    always #5 clk = ~clk;

    intersection_phase_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .car_req  (car_req),
`ifdef PED_PHASE_EN
        .ped_req  (ped_req),
        .walk     (walk),
`endif
        .lights   (lights),
        .cur_appr (cur_appr)
    );

    function automatic logic [11:0] lamp(input int appr, input logic [2:0] c);
        logic [11:0] l;
        l = ALL_R;
        l[3*appr +: 3] = c;
        return l;
    endfunction

    task automatic expect_n(input logic [11:0] l, input logic [1:0] a, input logic w,
                            input int n, input string tag);
        exp_t x;
        x.lights = l;
        x.appr   = a;
        x.walk   = w;
        x.tag    = tag;
        for (int i = 0; i < n; i++) exp_q.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (lights !== e.lights || cur_appr !== e.appr || walk !== e.walk) begin
                bad++;
                $display("FAIL %s t=%0t: got lights=%b appr=%0d walk=%b, required lights=%b appr=%0d walk=%b",
                         e.tag, $time, lights, cur_appr, walk, e.lights, e.appr, e.walk);
            end
        end
    end

    initial begin
        // Held in reset
        step(1);
        expect_n(RST_L, 2'd0, 1'b0, 2, "reset_state");
        step(2);

        // No requests: highway stays green
        rst_n = 1'b1; car_req = 4'b0000;
        expect_n(RST_L, 2'd0, 1'b0, 50, "idle_hold");
        step(50);
        rst_n = 1'b0;
        step(1);

        // Side request at approach 2, then idle return and reset during yellow
        rst_n = 1'b1; car_req = 4'b0100;
        expect_n(lamp(0, LIGHT_G), 2'd0, 1'b0, 4, "a2_grn0");
        expect_n(lamp(0, LIGHT_Y), 2'd0, 1'b0, 2, "a2_yel0");
        expect_n(ALL_R,            2'd0, 1'b0, 1, "a2_allred");
        step(7);
        car_req = 4'b0000;
        expect_n(lamp(2, LIGHT_G), 2'd2, 1'b0, 4, "a2_grn2");
        expect_n(lamp(2, LIGHT_Y), 2'd2, 1'b0, 1, "a2_yel2");
        expect_n(RST_L,            2'd0, 1'b0, 2, "reset_in_yellow");
        step(5);
        rst_n = 1'b0;
        step(2);

        // Contested highway hits GREEN_MAX, then rotation 1 -> 2 -> 3 -> 0
        rst_n = 1'b1; car_req = 4'b0011;
        expect_n(lamp(0, LIGHT_G), 2'd0, 1'b0, 12, "max_grn0");
        expect_n(lamp(0, LIGHT_Y), 2'd0, 1'b0, 2,  "max_yel0");
        expect_n(ALL_R,            2'd0, 1'b0, 1,  "max_allred0");
        expect_n(lamp(1, LIGHT_G), 2'd1, 1'b0, 1,  "max_grn1");
        step(15);
        car_req = 4'b1101;
        expect_n(lamp(1, LIGHT_G), 2'd1, 1'b0, 3,  "rot_grn1");
        expect_n(lamp(1, LIGHT_Y), 2'd1, 1'b0, 2,  "rot_yel1");
        expect_n(ALL_R,            2'd1, 1'b0, 1,  "rot_allred1");
        expect_n(lamp(2, LIGHT_G), 2'd2, 1'b0, 12, "rot_grn2");
        expect_n(lamp(2, LIGHT_Y), 2'd2, 1'b0, 2,  "rot_yel2");
        expect_n(ALL_R,            2'd2, 1'b0, 1,  "rot_allred2");
        expect_n(lamp(3, LIGHT_G), 2'd3, 1'b0, 12, "rot_grn3");
        expect_n(lamp(3, LIGHT_Y), 2'd3, 1'b0, 2,  "rot_yel3");
        expect_n(ALL_R,            2'd3, 1'b0, 1,  "rot_allred3");
        expect_n(lamp(0, LIGHT_G), 2'd0, 1'b0, 4,  "rot_grn0");
        step(41);
        rst_n = 1'b0; car_req = 4'b0000;
        step(1);

`ifdef PED_PHASE_EN
        // Pedestrian press during highway green with no cars
        rst_n = 1'b1; ped_req = 1'b1;
        expect_n(lamp(0, LIGHT_G), 2'd0, 1'b0, 4, "ped_grn0");
        expect_n(lamp(0, LIGHT_Y), 2'd0, 1'b0, 2, "ped_yel0");
        expect_n(ALL_R,            2'd0, 1'b0, 1, "ped_allred");
        expect_n(ALL_R,            2'd0, 1'b1, 6, "ped_walk");
        expect_n(lamp(0, LIGHT_G), 2'd0, 1'b0, 2, "ped_back_grn0");
        step(1);
        ped_req = 1'b0;
        step(14);
`endif

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step(1);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/intersection_phase_scheduler.md
INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green cycles per approach.
REQ-002 Parameter GREEN_MAX, default 12: maximum green cycles while other approaches wait; constraint GREEN_MAX >= GREEN_MIN >= 1.
REQ-003 Parameter YELLOW_CYC, default 2: yellow cycles.
REQ-004 Parameter ALLRED_CYC, default 1: all-red clearance cycles.
REQ-005 Parameter WALK_CYC, default 6: pedestrian walk cycles (used only under PED_PHASE_EN).
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 car_req  input  4  level car-present flag per approach; bit 0 is the highway default approach.
REQ-009 lights  output  12  light for approach i at [3i+2:3i]; 3'b100 green, 3'b010 yellow, 3'b001 red.
REQ-010 cur_appr  output  2  index of the approach owning the current phase.
REQ-011 ped_req  input  1  pedestrian button pulse (present only under PED_PHASE_EN).
REQ-012 walk  output  1  walk signal (present only under PED_PHASE_EN).

Function
REQ-013 FSM states GREEN, YELLOW, ALLRED, WALK (WALK only under PED_PHASE_EN); one phase timer, counting from 0 on state entry, saturating.
REQ-014 GREEN: lights[cur_appr]=green, all others red.
REQ-015 other_req = car_req with bit cur_appr masked (plus ped_pending under PED_PHASE_EN).
REQ-016 Exit GREEN on the edge where timer >= GREEN_MIN-1 AND other_req != 0 AND (car_req[cur_appr]==0 OR timer >= GREEN_MAX-1).
REQ-017 Exit GREEN also when cur_appr != 0, timer >= GREEN_MIN-1, and car_req == 0 and no ped pending; the next approach is then 0.
REQ-018 No exit condition: GREEN is held indefinitely; timer saturates.
REQ-019 At GREEN exit next_appr is latched: the first requesting approach after cur_appr in rotation order (cur+1, cur+2, cur+3 mod 4); 0 if none.
REQ-020 YELLOW lasts exactly YELLOW_CYC cycles, with lights[cur_appr]=yellow and all others red.
REQ-021 ALLRED lasts exactly ALLRED_CYC cycles with all lights red; then GREEN with cur_appr=next_appr and timer=0.
REQ-022 Request changes after latching do not alter next_appr; simultaneous requests are resolved only by the REQ-019 rotation.
REQ-023 Exactly one lamp is lit per approach in every cycle; at most one approach is non-red.

Reset
REQ-024 On rst_n low, immediately and asynchronously: state=GREEN, cur_appr=0, next_appr=0, timer=0, lights=12'b001_001_001_100, walk=0, ped_pending=0.
REQ-025 Reset asserted mid-phase (any state) aborts it; operation restarts from REQ-024 values after release.

Configuration
REQ-026 Macro PED_PHASE_EN: when defined, ped_req and walk exist, and ped_req sets sticky ped_pending.
REQ-027 With PED_PHASE_EN, at the end of ALLRED with ped_pending=1: WALK for WALK_CYC cycles with all red and walk=1; ped_pending clears on WALK entry; then GREEN for next_appr.
REQ-028 Without PED_PHASE_EN, the ports and the WALK state are absent, and behaviour is exactly REQ-013..REQ-025.

Structure
REQ-029 Shared package tlc_pkg holds the state enum, light encodings (LIGHT_G/LIGHT_Y/LIGHT_R) and the approach count constant (4).
REQ-030 Round-robin selection is the sub-module rr_arbiter4 (inputs req[3:0] and ptr[1:0]; outputs gnt_idx[1:0] and any).
REQ-031 The timer width is $clog2 of the largest duration parameter plus one.

Verification
REQ-032 Reset release, car_req=0 for 50 cycles -> lights stays 12'b001_001_001_100 and cur_appr=0 throughout.
REQ-033 car_req=4'b0100 held from reset release -> approach 0 green cycles 0-3, yellow 4-5, all-red 6, approach 2 green from cycle 7.
REQ-034 car_req=4'b0011 held -> approach 0 green for 12 cycles (GREEN_MAX cap), then yellow, all-red, approach 1 green.
REQ-035 cur_appr=1 green, car_req=4'b1101 -> next green is approach 2, then 3, then 0 (rotation).
REQ-036 rst_n pulsed low during YELLOW of approach 2 -> lights=12'b001_001_001_100 within the same cycle and cur_appr=0.
REQ-037 (PED_PHASE_EN) ped_req pulse during approach-0 green with car_req=0 -> after GREEN_MIN: yellow, all-red, 6 cycles walk=1 with all red, then approach 0 green.
